mesh_traffic_sequencer: RTL and testbench

- Control stage directly upstream of the 16-node loader/mesh/PMU cosimulation top.
- Accepts per-node traffic commands from the host, pushes each into the selected loader FIFO, and pulses start.
- Waits until all loaders report idle, then sweeps every PMU counter of every node and streams the values back to the host over a valid/ready channel.

---
 rtl/mesh_traffic_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_mesh_traffic_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_traffic_sequencer.sv
// Host-facing control stage for the loader/mesh/PMU cosim top: queues per-node loader
// commands, launches the loaders, waits for idle, then streams every PMU counter back.
module mesh_traffic_sequencer #(
  parameter int unsigned NODES          = 16,
  parameter int unsigned PMU_REGS       = 8,
  parameter int unsigned GUARD_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned NW = (NODES > 1) ? $clog2(NODES) : 1,
  localparam int unsigned RW = (PMU_REGS > 1) ? $clog2(PMU_REGS) : 1,
  localparam int unsigned GW = $clog2(GUARD_CYCLES + 1),
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [NW-1:0] cmd_node_i,
  input  logic [4:0]    cmd_id_i,
  input  logic          cmd_write_i,
  input  logic [7:0]    cmd_axlen_i,
  input  logic          cmd_resp_wait_i,
  input  logic          run_i,
  output logic [4:0]    id_o        [NODES],
  output logic          write_o     [NODES],
  output logic [7:0]    axlen_o     [NODES],
  output logic          resp_wait_o [NODES],
  output logic          fifo_push_o [NODES],
  output logic          start_o,
  input  logic          idle_i      [NODES],
  output logic [4:0]    pmu_addr_o  [NODES],
  input  logic [31:0]   pmu_data_i  [NODES],
  output logic          res_valid_o,
  input  logic          res_ready_i,
  output logic [NW-1:0] res_node_o,
  output logic [4:0]    res_addr_o,
  output logic [31:0]   res_data_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_GUARD, S_WAIT_IDLE, S_SWEEP, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [4:0]    id_q [NODES], id_d [NODES];
  logic          write_q [NODES], write_d [NODES];
  logic [7:0]    axlen_q [NODES], axlen_d [NODES];
  logic          resp_wait_q [NODES], resp_wait_d [NODES];
  logic          push_q [NODES], push_d [NODES];
  logic          start_q, start_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          timeout_q, timeout_d;
  logic [NW-1:0] node_q, node_d;
  logic [RW-1:0] reg_q, reg_d;
  logic          res_valid_q, res_valid_d;
  logic [NW-1:0] res_node_q, res_node_d;
  logic [4:0]    res_addr_q, res_addr_d;
  logic [31:0]   res_data_q, res_data_d;
  logic          all_idle;

  always_comb begin
    all_idle = 1'b1;
    for (int unsigned i = 0; i < NODES; i++) begin
      if (!idle_i[i]) all_idle = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    write_d     = write_q;
    axlen_d     = axlen_q;
    resp_wait_d = resp_wait_q;
    push_d      = '{default: 1'b0};
    start_d     = 1'b0;
    guard_d     = guard_q;
    wait_d      = wait_q;
    timeout_d   = timeout_q;
    node_d      = node_q;
    reg_d       = reg_q;
    res_valid_d = res_valid_q;
    res_node_d  = res_node_q;
    res_addr_d  = res_addr_q;
    res_data_d  = res_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          id_d[cmd_node_i]        = cmd_id_i;
          write_d[cmd_node_i]     = cmd_write_i;
          axlen_d[cmd_node_i]     = cmd_axlen_i;
          resp_wait_d[cmd_node_i] = cmd_resp_wait_i;
          push_d[cmd_node_i]      = 1'b1;
        end
        if (run_i) begin
          state_d   = S_START;
          timeout_d = 1'b0;
        end
      end
      // start_o is registered so a same-cycle command push always lands a cycle ahead of it
      S_START: begin
        start_d = 1'b1;
        guard_d = GW'(GUARD_CYCLES - 1);
        state_d = S_GUARD;
      end
      S_GUARD: begin
        if (guard_q == '0) begin
          state_d = S_WAIT_IDLE;
          wait_d  = '0;
        end else begin
          guard_d = guard_q - 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (all_idle) begin
          state_d = S_SWEEP;
          node_d  = '0;
          reg_d   = '0;
        end else if (wait_q == CW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_SWEEP;
          node_d    = '0;
          reg_d     = '0;
        end else if (wait_q != '1) begin
          wait_d = wait_q + 1'b1;
        end
      end
      // Alternate capture and present phases: one result per two cycles at best
      S_SWEEP: begin
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
          res_node_d  = node_q;
          res_addr_d  = 5'(reg_q);
          res_data_d  = pmu_data_i[node_q];
        end else if (res_ready_i) begin
          res_valid_d = 1'b0;
          if (node_q == NW'(NODES - 1) && reg_q == RW'(PMU_REGS - 1)) begin
            state_d = S_DONE;
          end else if (reg_q == RW'(PMU_REGS - 1)) begin
            reg_d  = '0;
            node_d = node_q + 1'b1;
          end else begin
            reg_d = reg_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      id_q        <= '{default: '0};
      write_q     <= '{default: 1'b0};
      axlen_q     <= '{default: '0};
      resp_wait_q <= '{default: 1'b0};
      push_q      <= '{default: 1'b0};
      start_q     <= 1'b0;
      guard_q     <= '0;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
      node_q      <= '0;
      reg_q       <= '0;
      res_valid_q <= 1'b0;
      res_node_q  <= '0;
      res_addr_q  <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      write_q     <= write_d;
      axlen_q     <= axlen_d;
      resp_wait_q <= resp_wait_d;
      push_q      <= push_d;
      start_q     <= start_d;
      guard_q     <= guard_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
      node_q      <= node_d;
      reg_q       <= reg_d;
      res_valid_q <= res_valid_d;
      res_node_q  <= res_node_d;
      res_addr_q  <= res_addr_d;
      res_data_q  <= res_data_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NODES; i++) begin
      pmu_addr_o[i] = '0;
      if (state_q == S_SWEEP && node_q == NW'(i)) pmu_addr_o[i] = 5'(reg_q);
    end
  end

  assign id_o        = id_q;
  assign write_o     = write_q;
  assign axlen_o     = axlen_q;
  assign resp_wait_o = resp_wait_q;
  assign fifo_push_o = push_q;
  assign start_o     = start_q;
  assign res_valid_o = res_valid_q;
  assign res_node_o  = res_node_q;
  assign res_addr_o  = res_addr_q;
  assign res_data_o  = res_data_q;
  assign timeout_o   = timeout_q;
  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_mesh_traffic_sequencer.sv
// Scoreboard bench for mesh_traffic_sequencer: expected sweep results are queued at run
// launch from a plain node/register model and popped by an independent result monitor.
module tb_mesh_traffic_sequencer;
  localparam int NODES      = 16;
  localparam int PMU_REGS   = 8;
  localparam int GUARD      = 4;
  localparam int TB_TIMEOUT = 120;

  typedef struct packed {
    logic [3:0]  node;
    logic [4:0]  addr;
    logic [31:0] data;
  } res_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid_i, cmd_ready_o;
  logic [3:0]  cmd_node_i;
  logic [4:0]  cmd_id_i;
  logic        cmd_write_i;
  logic [7:0]  cmd_axlen_i;
  logic        cmd_resp_wait_i;
  logic        run_i;
  logic [4:0]  id_o [NODES];
  logic        write_o [NODES];
  logic [7:0]  axlen_o [NODES];
  logic        resp_wait_o [NODES];
  logic        fifo_push_o [NODES];
  logic        start_o;
  logic        idle_i [NODES];
  logic [4:0]  pmu_addr_o [NODES];
  logic [31:0] pmu_data_i [NODES];
  logic        res_valid_o, res_ready_i;
  logic [3:0]  res_node_o;
  logic [4:0]  res_addr_o;
  logic [31:0] res_data_o;
  logic        busy_o, done_o, timeout_o;

  mesh_traffic_sequencer #(
    .NODES(NODES), .PMU_REGS(PMU_REGS), .GUARD_CYCLES(GUARD), .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_node_i(cmd_node_i),
    .cmd_id_i(cmd_id_i), .cmd_write_i(cmd_write_i), .cmd_axlen_i(cmd_axlen_i),
    .cmd_resp_wait_i(cmd_resp_wait_i), .run_i(run_i),
    .id_o(id_o), .write_o(write_o), .axlen_o(axlen_o), .resp_wait_o(resp_wait_o),
    .fifo_push_o(fifo_push_o), .start_o(start_o), .idle_i(idle_i),
    .pmu_addr_o(pmu_addr_o), .pmu_data_i(pmu_data_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_node_o(res_node_o),
    .res_addr_o(res_addr_o), .res_data_o(res_data_o),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          done_cnt = 0;
  int          n_res    = 0;
  logic        rnd_ready = 1'b0;
  logic [15:0] salt = '0;
  res_t        sb[$];
  logic [4:0]  m_id [NODES];
  logic        m_write [NODES];
  logic [7:0]  m_axlen [NODES];
  logic        m_rw [NODES];

  initial forever #5 aclk = ~aclk;
  initial forever begin @(posedge aclk); cyc++; end

  // PMU model: each counter reads back a value encoding run salt, node and address
  always_comb begin
    for (int i = 0; i < NODES; i++) pmu_data_i[i] = {salt, 8'(i), 3'b000, pmu_addr_o[i]};
  end

  initial begin
    res_ready_i = 1'b1;
    forever begin
      @(posedge aclk); #1;
      res_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result monitor: pops the scoreboard on every handshake, checks stall stability
  initial begin
    logic       prev_stall = 1'b0;
    logic [40:0] held = '0;
    res_t       e;
    forever begin
      @(negedge aclk);
      if (done_o) done_cnt++;
      if (prev_stall)
        check("stall_stable", 64'({res_valid_o, res_node_o, res_addr_o, res_data_o}),
              64'({1'b1, held}));
      if (!areset && res_valid_o && res_ready_i) begin
        n_res++;
        check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("res_node_addr", 64'({res_node_o, res_addr_o}), 64'({e.node, e.addr}));
          check("res_data", 64'(res_data_o), 64'(e.data));
        end
      end
      prev_stall = !areset && res_valid_o && !res_ready_i;
      held       = {res_node_o, res_addr_o, res_data_o};
    end
  end

  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic get_push(output logic [NODES-1:0] v);
    for (int i = 0; i < NODES; i++) v[i] = fifo_push_o[i];
  endtask

  task automatic launch();
    res_t e;
    salt = 16'($urandom);
    for (int n = 0; n < NODES; n++)
      for (int r = 0; r < PMU_REGS; r++) begin
        e.node = 4'(n);
        e.addr = 5'(r);
        e.data = {salt, 8'(n), 3'b000, 5'(r)};
        sb.push_back(e);
      end
  endtask

  task automatic start_run();
    step(); run_i = 1'b1; launch();
    step(); run_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int   d0  = done_cnt;
    logic got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge aclk);
      if (done_cnt != d0) got = 1'b1;
    end
    check("done_seen", 64'(got), 64'(1));
    check("sb_empty_at_done", 64'(sb.size()), 64'(0));
    repeat (3) @(negedge aclk);
    check("done_once", 64'(done_cnt - d0), 64'(1));
    check("idle_after_done", 64'({busy_o, cmd_ready_o}), 64'(2'b01));
  endtask

  task automatic check_fields();
    for (int i = 0; i < NODES; i++)
      check("node_fields", 64'({id_o[i], write_o[i], axlen_o[i], resp_wait_o[i]}),
            64'({m_id[i], m_write[i], m_axlen[i], m_rw[i]}));
  endtask

  task automatic clear_model();
    for (int i = 0; i < NODES; i++) begin
      m_id[i] = '0; m_write[i] = 1'b0; m_axlen[i] = '0; m_rw[i] = 1'b0;
    end
  endtask

  initial begin
    logic [NODES-1:0] pv;
    logic [3:0]  pn;
    logic [4:0]  pid;
    logic        pw, prw, seen_valid, seen_push, acc;
    logic [7:0]  pl;
    int          cs, ct, base;

    areset = 1'b1; cmd_valid_i = 1'b0; cmd_node_i = '0; cmd_id_i = '0; cmd_write_i = 1'b0;
    cmd_axlen_i = '0; cmd_resp_wait_i = 1'b0; run_i = 1'b0;
    for (int i = 0; i < NODES; i++) idle_i[i] = 1'b1;
    clear_model();
    pn = '0; pid = '0; pw = 1'b0; pl = '0; prw = 1'b0;
    repeat (3) step();
    areset = 1'b0;
    @(negedge aclk);

    // Reset state
    check("reset_ctrl", 64'({cmd_ready_o, busy_o, start_o, res_valid_o, done_o, timeout_o}),
          64'(6'b100000));
    acc = 1'b0;
    for (int i = 0; i < NODES; i++)
      acc |= (|id_o[i]) | write_o[i] | (|axlen_o[i]) | resp_wait_o[i] | fifo_push_o[i]
           | (|pmu_addr_o[i]);
    check("reset_fields_zero", 64'(acc), 64'(0));

    // Single command, then run on the following cycle
    step();
    cmd_valid_i = 1'b1; cmd_node_i = 4'd3; cmd_id_i = 5'd5; cmd_write_i = 1'b1;
    cmd_axlen_i = 8'd7; cmd_resp_wait_i = 1'b0;
    m_id[3] = 5'd5; m_write[3] = 1'b1; m_axlen[3] = 8'd7; m_rw[3] = 1'b0;
    @(negedge aclk);
    check("t1_cmd_ready", 64'(cmd_ready_o), 64'(1));
    step(); cmd_valid_i = 1'b0; run_i = 1'b1; launch();
    @(negedge aclk);
    get_push(pv);
    check("t1_push", 64'(pv), 64'(16'h0008));
    check("t1_fields", 64'({id_o[3], write_o[3], axlen_o[3]}), 64'({5'd5, 1'b1, 8'd7}));
    check("t1_start_early", 64'(start_o), 64'(0));
    step(); run_i = 1'b0;
    @(negedge aclk);
    get_push(pv);
    check("t1_push_one_cycle", 64'(pv), 64'(0));
    check("t1_busy", 64'({start_o, cmd_ready_o, busy_o}), 64'(3'b001));
    step(); @(negedge aclk);
    check("t1_start", 64'(start_o), 64'(1));
    step(); @(negedge aclk);
    check("t1_start_one_cycle", 64'(start_o), 64'(0));
    wait_done(2000);

    // Back-to-back commands, including a repeated node
    for (int k = 0; k <= 20; k++) begin
      step();
      if (k < 20) begin
        cmd_valid_i = 1'b1;
        cmd_node_i = (k == 5) ? pn : 4'($urandom_range(0, NODES - 1));
        cmd_id_i = 5'($urandom); cmd_write_i = 1'($urandom);
        cmd_axlen_i = 8'($urandom); cmd_resp_wait_i = 1'($urandom);
      end else begin
        cmd_valid_i = 1'b0;
      end
      @(negedge aclk);
      if (k > 0) begin
        get_push(pv);
        check("burst_push", 64'(pv), 64'(16'(1) << pn));
        check("burst_fields", 64'({id_o[pn], write_o[pn], axlen_o[pn], resp_wait_o[pn]}),
              64'({pid, pw, pl, prw}));
      end
      if (k < 20) begin
        pn = cmd_node_i; pid = cmd_id_i; pw = cmd_write_i; pl = cmd_axlen_i;
        prw = cmd_resp_wait_i;
        m_id[pn] = pid; m_write[pn] = pw; m_axlen[pn] = pl; m_rw[pn] = prw;
      end
    end
    check_fields();

    // Command and run in the same cycle, random result back-pressure
    rnd_ready = 1'b1;
    step();
    cmd_valid_i = 1'b1; cmd_node_i = 4'd9; cmd_id_i = 5'd17; cmd_write_i = 1'b0;
    cmd_axlen_i = 8'd200; cmd_resp_wait_i = 1'b1; run_i = 1'b1;
    m_id[9] = 5'd17; m_write[9] = 1'b0; m_axlen[9] = 8'd200; m_rw[9] = 1'b1;
    launch();
    @(negedge aclk);
    check("t2_cmd_ready", 64'(cmd_ready_o), 64'(1));
    step(); cmd_valid_i = 1'b0; run_i = 1'b0;
    @(negedge aclk);
    get_push(pv);
    check("t2_push", 64'(pv), 64'(16'h0200));
    check("t2_ready_start", 64'({cmd_ready_o, start_o}), 64'(2'b00));
    step(); @(negedge aclk);
    get_push(pv);
    check("t2_start_after_push", 64'({start_o, pv}), 64'({1'b1, 16'h0000}));
    wait_done(3000);
    check_fields();

    // One loader stays busy; commands and run pulses while busy are ignored
    idle_i[7] = 1'b0;
    start_run();
    seen_valid = 1'b0; seen_push = 1'b0;
    cmd_valid_i = 1'b1; cmd_node_i = 4'd2; cmd_id_i = ~m_id[2]; run_i = 1'b1;
    repeat (100) begin
      @(negedge aclk);
      if (res_valid_o) seen_valid = 1'b1;
      get_push(pv);
      if (pv != '0) seen_push = 1'b1;
    end
    step(); cmd_valid_i = 1'b0; run_i = 1'b0; idle_i[7] = 1'b1;
    check("t3_no_res_before_idle", 64'(seen_valid), 64'(0));
    check("t3_no_push_while_busy", 64'(seen_push), 64'(0));
    wait_done(3000);
    check("t3_no_timeout", 64'(timeout_o), 64'(0));
    check_fields();

    // Timeout with a stuck loader; sweep still completes, next launch clears the flag
    idle_i[0] = 1'b0;
    start_run();
    cs = -1; ct = -1;
    for (int k = 0; k < 400 && ct < 0; k++) begin
      @(negedge aclk);
      if (start_o && cs < 0) cs = cyc;
      if (timeout_o && ct < 0) ct = cyc;
    end
    check("t4_timeout_latency", 64'(ct - cs), 64'(GUARD + TB_TIMEOUT));
    wait_done(3000);
    check("t4_timeout_sticky", 64'(timeout_o), 64'(1));
    idle_i[0] = 1'b1;
    start_run();
    @(negedge aclk);
    check("t4_timeout_cleared", 64'(timeout_o), 64'(0));
    wait_done(3000);

    // Reset in the middle of a sweep
    base = n_res;
    start_run();
    for (int k = 0; k < 2000 && (n_res - base) < 40; k++) @(negedge aclk);
    check("t5_reached_40", 64'((n_res - base) >= 40), 64'(1));
    base = done_cnt;
    step(); areset = 1'b1;
    step(); areset = 1'b0;
    sb.delete();
    clear_model();
    @(negedge aclk);
    check("t5_after_reset", 64'({cmd_ready_o, busy_o, res_valid_o, timeout_o}),
          64'(4'b1000));
    repeat (20) @(negedge aclk);
    check("t5_no_done", 64'(done_cnt - base), 64'(0));
    check_fields();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
